// File: rtl/hazard_pkg.sv
// Shared encodings for the RV32I hazard unit: forwarding selects, result-source
// decode and the two-state multi-cycle execute FSM.
package hazard_pkg;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [2:0] RES_LOAD = 3'b001;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding select for the E stage; M beats W, x0 is never forwarded.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_E,
    input  logic [REG_AW-1:0] rd_M,
    input  logic [REG_AW-1:0] rd_W,
    input  logic              regWrite_M,
    input  logic              regWrite_W,
    output logic [1:0]        fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (regWrite_M && (rd_M != '0) && (rd_M == rs_E)) begin
            fwd = FWD_MEM;
        end else if (regWrite_W && (rd_W != '0) && (rd_W == rs_E)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage RV32I pipeline: forwarding, load-use bubbles,
// multi-cycle execute hold and branch flush. HAZ_PERF_CNT_EN adds stall/flush counters.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int MDU_LAT  = 4,
    parameter int CNT_W    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1_D,
    input  logic [REG_AW-1:0] rs2_D,
    input  logic [REG_AW-1:0] rs1_E,
    input  logic [REG_AW-1:0] rs2_E,
    input  logic [REG_AW-1:0] rd_E,
    input  logic              regWrite_E,
    input  logic [2:0]        resultSrc_E,
    input  logic              mdu_op_E,
    input  logic              PCSrc_E,
    input  logic [REG_AW-1:0] rd_M,
    input  logic [REG_AW-1:0] rd_W,
    input  logic              regWrite_M,
    input  logic              regWrite_W,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              stall_F,
    output logic              stall_D,
    output logic              stall_E,
    output logic              flush_D,
    output logic              flush_E,
    output logic              flush_M,
    output logic              mdu_busy
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_cycles
`endif
);

    localparam logic [CNT_W-1:0] LD_RELOAD  = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] MDU_RELOAD = CNT_W'(MDU_LAT - 2);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;
    logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d;

    logic mdu_stall;
    logic ld_active;
    logic load_use;
    logic ld_detect;
    logic ld_stall;

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs_E       (rs1_E),
        .rd_M       (rd_M),
        .rd_W       (rd_W),
        .regWrite_M (regWrite_M),
        .regWrite_W (regWrite_W),
        .fwd        (forwardAE)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs_E       (rs2_E),
        .rd_M       (rd_M),
        .rd_W       (rd_W),
        .regWrite_M (regWrite_M),
        .regWrite_W (regWrite_W),
        .fwd        (forwardBE)
    );

    // The final BUSY cycle releases the stall so the op leaves E on that edge.
    always_comb begin
        state_d   = state_q;
        mdu_cnt_d = mdu_cnt_q;
        mdu_stall = 1'b0;
        mdu_busy  = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                if (mdu_op_E) begin
                    mdu_stall = 1'b1;
                    mdu_busy  = 1'b1;
                    mdu_cnt_d = MDU_RELOAD;
                    state_d   = MDU_BUSY;
                end
            end
            MDU_BUSY: begin
                mdu_busy = 1'b1;
                if (mdu_cnt_q != '0) begin
                    mdu_stall = 1'b1;
                    mdu_cnt_d = mdu_cnt_q - 1'b1;
                end else begin
                    state_d = MDU_IDLE;
                end
            end
            default: begin
                state_d   = MDU_IDLE;
                mdu_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        ld_active = (ld_cnt_q != '0);
        load_use  = (resultSrc_E == RES_LOAD) && regWrite_E && (rd_E != '0) &&
                    ((rd_E == rs1_D) || (rd_E == rs2_D));
        ld_detect = !mdu_stall && !ld_active && load_use;
        ld_stall  = ld_active || ld_detect;

        ld_cnt_d = '0;
        if (PCSrc_E) begin
            ld_cnt_d = '0;
        end else if (ld_active) begin
            ld_cnt_d = ld_cnt_q - 1'b1;
        end else if (ld_detect) begin
            ld_cnt_d = LD_RELOAD;
        end
    end

    // A taken branch squashes the load bubble: the dependent instruction is flushed anyway.
    always_comb begin
        stall_F = (ld_stall && !PCSrc_E) || mdu_stall;
        stall_D = (ld_stall && !PCSrc_E) || mdu_stall;
        stall_E = mdu_stall;
        flush_D = PCSrc_E;
        flush_E = ld_stall || PCSrc_E;
        flush_M = mdu_stall;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= MDU_IDLE;
            mdu_cnt_q <= '0;
            ld_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            mdu_cnt_q <= mdu_cnt_d;
            ld_cnt_q  <= ld_cnt_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_cycles_q, flush_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_cycles_d = flush_cycles_q;
        if (stall_D && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (flush_D && (flush_cycles_q != 32'hFFFF_FFFF)) begin
            flush_cycles_d = flush_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_cycles_q <= flush_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_cycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc (LOAD_LAT=2, MDU_LAT=4) with a cycle-level reference model.
module tb_hazard_unit_mc;

    localparam int LL = 2;
    localparam int ML = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic       regWrite_E, regWrite_M, regWrite_W;
    logic [2:0] resultSrc_E;
    logic       mdu_op_E, PCSrc_E;
    logic [1:0] forwardAE, forwardBE;
    logic       stall_F, stall_D, stall_E, flush_D, flush_E, flush_M, mdu_busy;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: cycles the current MDU op has already spent in E, and load bubbles still owed.
    int m_age   = 0;
    int ld_owed = 0;
    int perf_s  = 0;
    int perf_f  = 0;

    always #5 clk = ~clk;

    hazard_unit_mc #(.REG_AW(5), .LOAD_LAT(LL), .MDU_LAT(ML), .CNT_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs1_D       (rs1_D),
        .rs2_D       (rs2_D),
        .rs1_E       (rs1_E),
        .rs2_E       (rs2_E),
        .rd_E        (rd_E),
        .regWrite_E  (regWrite_E),
        .resultSrc_E (resultSrc_E),
        .mdu_op_E    (mdu_op_E),
        .PCSrc_E     (PCSrc_E),
        .rd_M        (rd_M),
        .rd_W        (rd_W),
        .regWrite_M  (regWrite_M),
        .regWrite_W  (regWrite_W),
        .forwardAE   (forwardAE),
        .forwardBE   (forwardBE),
        .stall_F     (stall_F),
        .stall_D     (stall_D),
        .stall_E     (stall_E),
        .flush_D     (flush_D),
        .flush_E     (flush_E),
        .flush_M     (flush_M),
        .mdu_busy    (mdu_busy)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_cycles(flush_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (regWrite_M && rd_M != 0 && rd_M == rs) return 2'b10;
        if (regWrite_W && rd_W != 0 && rd_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
        regWrite_E = 0; regWrite_M = 0; regWrite_W = 0;
        resultSrc_E = 3'b000; mdu_op_E = 0; PCSrc_E = 0;
    endtask

    // Compare every output at the negedge, then advance the model across the posedge.
    task automatic cycle();
        int cur;
        bit se, lu, det, ldn, sd;
        @(negedge clk);
        cur = (m_age > 0) ? m_age + 1 : (mdu_op_E ? 1 : 0);
        se  = (cur > 0) && (cur < ML);
        lu  = (resultSrc_E == 3'b001) && regWrite_E && (rd_E != 0) &&
              ((rd_E == rs1_D) || (rd_E == rs2_D));
        det = (ld_owed == 0) && !se && lu;
        ldn = (ld_owed > 0) || det;
        sd  = (ldn && !PCSrc_E) || se;
        chk("forwardAE", 32'(forwardAE), 32'(fwd_ref(rs1_E)));
        chk("forwardBE", 32'(forwardBE), 32'(fwd_ref(rs2_E)));
        chk("stall_F",   32'(stall_F),   32'(sd));
        chk("stall_D",   32'(stall_D),   32'(sd));
        chk("stall_E",   32'(stall_E),   32'(se));
        chk("flush_D",   32'(flush_D),   32'(PCSrc_E));
        chk("flush_E",   32'(flush_E),   32'(ldn || PCSrc_E));
        chk("flush_M",   32'(flush_M),   32'(se));
        chk("mdu_busy",  32'(mdu_busy),  32'(cur > 0));
        chk("no_branch_while_busy", 32'(PCSrc_E && mdu_busy), 32'd0);
`ifdef HAZ_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, 32'(perf_s));
        chk("flush_cycles", flush_cycles, 32'(perf_f));
`endif
        @(posedge clk);
        if (!rst_n) begin
            m_age = 0; ld_owed = 0; perf_s = 0; perf_f = 0;
        end else begin
            m_age   = se ? cur : 0;
            ld_owed = PCSrc_E ? 0 : ((ld_owed > 0 ? ld_owed : (det ? LL : 0)) - (ldn ? 1 : 0));
            perf_s += int'(sd);
            perf_f += int'(PCSrc_E);
        end
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        cycle();
        cycle();
        rst_n = 1;
    endtask

    function automatic logic [4:0] rnd_reg();
        return 5'($urandom_range(0, 3));
    endfunction

    initial begin
        int stall_cnt;
        clear_inputs();
        do_reset();
        cycle();
        chk("reset_stall_D", 32'(stall_D), 32'd0);

        // Forwarding: M wins over W; x0 never forwarded.
        rd_M = 5; rd_W = 5; rs1_E = 5; regWrite_M = 1; regWrite_W = 1;
        #1 chk("fwd_m_priority", 32'(forwardAE), 32'b10);
        cycle();
        rd_M = 0; rd_W = 0; rs1_E = 0;
        #1 chk("fwd_x0", 32'(forwardAE), 32'b00);
        cycle();
        rd_M = 0; rd_W = 9; rs2_E = 9;
        #1 chk("fwd_w_only", 32'(forwardBE), 32'b01);
        cycle();
        clear_inputs();

        // Load-use with LOAD_LAT=2: exactly two bubbles.
        rd_E = 7; rs2_D = 7; regWrite_E = 1; resultSrc_E = 3'b001;
        stall_cnt = 0;
        #1 stall_cnt += int'(stall_D);
        cycle();
        rd_E = 0; regWrite_E = 0; resultSrc_E = 3'b000;
        #1 stall_cnt += int'(stall_D);
        cycle();
        #1 chk("ld_bubbles_done", 32'(stall_F), 32'd0);
        chk("ld_bubble_count", 32'(stall_cnt), 32'(LL));
        cycle();
        clear_inputs();

        // MDU with MDU_LAT=4: three stalled cycles, busy for four.
        mdu_op_E = 1;
        for (int i = 0; i < ML; i++) begin
            #1 chk("mdu_stall_E_seq", 32'(stall_E), 32'(i < ML - 1));
            chk("mdu_busy_seq", 32'(mdu_busy), 32'd1);
            cycle();
        end
        mdu_op_E = 0;
        #1 chk("mdu_idle_after", 32'(mdu_busy), 32'd0);
        cycle();

        // Back-to-back MDU ops.
        mdu_op_E = 1;
        for (int i = 0; i < 2 * ML; i++) cycle();
        mdu_op_E = 0;
        cycle();

        // Branch and load-use in the same cycle: branch wins, no residual bubble.
        rd_E = 3; rs1_D = 3; regWrite_E = 1; resultSrc_E = 3'b001; PCSrc_E = 1;
        #1 chk("br_over_ld_stall", 32'(stall_F), 32'd0);
        chk("br_over_ld_flushE", 32'(flush_E), 32'd1);
        cycle();
        clear_inputs();
        #1 chk("br_ld_cnt_cleared", 32'(stall_D), 32'd0);
        cycle();

        // Reset in the middle of an MDU op.
        mdu_op_E = 1;
        cycle();
        rst_n = 0;
        cycle();
        rst_n = 1; mdu_op_E = 0;
        #1 chk("rst_mid_mdu_busy", 32'(mdu_busy), 32'd0);
        chk("rst_mid_mdu_stall", 32'(stall_E), 32'd0);
        cycle();

        // Randomized legal traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            rs1_D = rnd_reg(); rs2_D = rnd_reg();
            rs1_E = rnd_reg(); rs2_E = rnd_reg(); rd_E = rnd_reg();
            rd_M = rnd_reg(); rd_W = rnd_reg();
            regWrite_E = 1'($urandom_range(0, 1));
            regWrite_M = 1'($urandom_range(0, 1));
            regWrite_W = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: resultSrc_E = 3'b001;
                1: resultSrc_E = 3'b000;
                default: resultSrc_E = 3'b010;
            endcase
            if (m_age > 0)        mdu_op_E = 1;
            else if (ld_owed > 0) mdu_op_E = 0;
            else                  mdu_op_E = ($urandom_range(0, 9) == 0);
            if (mdu_op_E) resultSrc_E = 3'b000;
            PCSrc_E = !mdu_op_E && (m_age == 0) && ($urandom_range(0, 7) == 0);
            cycle();
        end
        rst_n = 1;
        clear_inputs();
        cycle();

`ifdef HAZ_PERF_CNT_EN
        // Three load-use bubbles plus one branch.
        do_reset();
        rd_E = 7; rs1_D = 7; regWrite_E = 1; resultSrc_E = 3'b001;
        cycle();
        clear_inputs();
        cycle();
        rd_E = 7; rs1_D = 7; regWrite_E = 1; resultSrc_E = 3'b001;
        cycle();
        clear_inputs();
        PCSrc_E = 1;
        cycle();
        clear_inputs();
        chk("perf_stall_3", stall_cycles, 32'd3);
        chk("perf_flush_1", flush_cycles, 32'd1);
        cycle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
Parametrised next-generation hazard unit for the RV32I 5-stage pipeline (F/D/E/M/W). It covers operand forwarding into E with x0 exclusion, and load-use stalls with a configurable bubble count. It also adds a multi-cycle execute handshake: E is held for MDU_LAT cycles for mul/div ops. Branch/jump flushing completes the set. It sits beside the datapath and drives all stage enables and flushes.

Parameters:
REG_AW, 5, register-address width (32 architectural registers)
LOAD_LAT, 1, load-use bubbles inserted per load-use hazard (legal range 1..3)
MDU_LAT, 4, total cycles a multi-cycle op occupies E (legal range 2..32)
CNT_W, 5, width of the internal down-counters; must hold max(LOAD_LAT, MDU_LAT)

Ports:
clk  in  1  pipeline clock
rst_n  in  1  synchronous active-low reset
rs1_D, rs2_D  in  REG_AW  source registers of the D-stage instruction
rs1_E, rs2_E, rd_E  in  REG_AW  E-stage source and destination registers
regWrite_E  in  1  E-stage instruction writes rd
resultSrc_E  in  3  E-stage result select; 3'b001 = load
mdu_op_E  in  1  E-stage instruction is multi-cycle (mul/div)
PCSrc_E  in  1  taken branch/jump resolved in E
rd_M, rd_W  in  REG_AW  destinations in M and W
regWrite_M, regWrite_W  in  1  write enables in M and W
forwardAE, forwardBE  out  2  operand select: 00 regfile, 01 W, 10 M
stall_F, stall_D, stall_E  out  1  hold the PC / IF-ID / ID-EX registers
flush_D, flush_E, flush_M  out  1  bubble the IF-ID / ID-EX / EX-MEM registers
mdu_busy  out  1  multi-cycle op in progress

Behaviour:
- Reset (rst_n=0 at posedge): FSM=IDLE, ld_cnt=0, mdu_cnt=0.
- After reset, every stall and flush output is 0 in the first cycle unless a combinational hazard condition is present.
- Forwarding (combinational): forwardXE = 10 if regWrite_M, rd_M==rsX_E and rd_M!=0.
  - Otherwise 01 if regWrite_W, rd_W==rsX_E and rd_W!=0.
  - Otherwise 00. M has priority over W.
- Load-use detect: resultSrc_E==3'b001, regWrite_E, rd_E!=0, and (rd_E==rs1_D or rd_E==rs2_D).
- Load-use response:
  - Detect cycle: stall_F=stall_D=flush_E=1; ld_cnt loads LOAD_LAT-1.
  - While ld_cnt!=0: the same three outputs are held at 1, ld_cnt decrements, and the detect logic is not re-evaluated.
  - Bubbles inserted = LOAD_LAT exactly.
- MDU FSM has two states, IDLE and BUSY:
  - IDLE with mdu_op_E=1: stall_F/D/E=1, flush_M=1, mdu_busy=1; mdu_cnt loads MDU_LAT-2; next state BUSY.
  - BUSY with mdu_cnt!=0: stall_F/D/E=1, flush_M=1, mdu_busy=1; mdu_cnt decrements.
  - BUSY with mdu_cnt==0: all MDU stalls drop, mdu_busy=1 for this final cycle; the op leaves E at the clock edge; next state IDLE.
  - E occupancy = MDU_LAT cycles; stalled cycles = MDU_LAT-1.
  - Back-to-back MDU ops re-trigger from IDLE with no dead cycle.
- Flush: PCSrc_E=1 sets flush_D=flush_E=1.
- Priority:
  - PCSrc_E overrides a load-use stall in the same cycle: stall_F/D=0, ld_cnt cleared.
  - MDU stall overrides a load-use detect: the detect is not evaluated while stall_E=1.
  - PCSrc_E while BUSY is illegal, because an MDU op never branches; the bench asserts this never occurs.
- Reset mid-operation (ld_cnt!=0 or BUSY): next cycle IDLE, counters 0, no residual stall.

Optional Feature:
Macro HAZ_PERF_CNT_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_cycles[31:0].
  - stall_cycles increments on each cycle with stall_D=1; flush_cycles on each cycle with flush_D=1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package hazard_pkg: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, RES_LOAD=3'b001, the MDU state encoding (IDLE=1'b0, BUSY=1'b1).
- One sub-module, hazard_fwd_sel: combinational per-operand priority comparator, instantiated for operand A and operand B.

Test Plan:
- Forwarding: rd_M=rd_W=rs1_E=5, both regWrite=1 -> forwardAE=10. Same with rd_M=0 and rs1_E=0 -> forwardAE=00 (x0 never forwarded).
- Load-use, LOAD_LAT=2: load in E with rd_E=7, rs2_D=7 -> stall_F/D=flush_E=1 for exactly 2 cycles, then 0.
- MDU, MDU_LAT=4: mdu_op_E=1 at cycle t -> stall_E=1 at t..t+2, 0 at t+3; mdu_busy=1 at t..t+3; IDLE at t+4.
- Branch vs load-use same cycle: PCSrc_E=1 and load-use detect -> flush_D=flush_E=1, stall_F=stall_D=0, ld_cnt=0 next cycle.
- Reset mid-MDU: rst_n=0 at cycle t+1 of the MDU sequence -> cycle t+2 has FSM=IDLE, all stalls 0, mdu_busy=0.
- HAZ_PERF_CNT_EN defined: 3 load-use bubbles plus 1 branch -> stall_cycles=3, flush_cycles=1.
